// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - multi-digit BCD adder sharing one digit add/correct stage, LSD first
// One digit is processed per clock; Sum/Cout/err update only on the completion edge.
module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   input  logic                  Cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   Sum,
   output logic                  Cout,
   output logic                  err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int W     = 4 * DIGITS;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            r_state;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [W-1:0]      r_part;
   logic              r_carry;
   logic              r_err_acc;
   logic [IDX_W-1:0]  r_idx;

   logic [3:0]        w_a_dig;
   logic [3:0]        w_b_dig;
   logic [4:0]        w_raw;
   logic              w_carry_next;
   logic [3:0]        w_dig;
   logic              w_bad_dig;
   logic              w_last;
   logic [W-1:0]      w_part_next;

   // Digit select and partial-sum slot write are explicit muxes over the index.
   always_comb begin
      w_a_dig     = 4'd0;
      w_b_dig     = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_a_dig = r_a[i*4 +: 4];
            w_b_dig = r_b[i*4 +: 4];
         end
      end
      w_raw        = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};
      w_carry_next = (w_raw > 5'd9);
      w_dig        = w_carry_next ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
      w_bad_dig    = (w_a_dig > 4'd9) | (w_b_dig > 4'd9);
      w_last       = (r_idx == IDX_W'(DIGITS - 1));
      w_part_next  = r_part;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_part_next[i*4 +: 4] = w_dig;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_part    <= '0;
         r_carry   <= 1'b0;
         r_err_acc <= 1'b0;
         r_idx     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Sum       <= '0;
         Cout      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a       <= A;
                  r_b       <= B;
                  r_carry   <= Cin;
                  r_part    <= '0;
                  r_err_acc <= 1'b0;
                  r_idx     <= '0;
                  busy      <= 1'b1;
                  r_state   <= RUN;
               end
            end
            RUN: begin
               r_part    <= w_part_next;
               r_carry   <= w_carry_next;
               r_err_acc <= r_err_acc | w_bad_dig;
               if (w_last) begin
                  Sum     <= w_part_next;
                  Cout    <= w_carry_next;
                  err     <= r_err_acc | w_bad_dig;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_idx   <= '0;
                  r_state <= IDLE;
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - randomized self-checking bench against a digit-rule reference model
module tb_bcd_serial_adder_ctrl;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  Sum;
   logic          Cout;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Cin(Cin),
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: per-digit decimal add with +6 correction, plain integer arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output logic e);
      int carry, ai, bi, raw, d;
      carry = c;
      e = 1'b0;
      s = '0;
      for (int i = 0; i < D; i++) begin
         ai  = int'(a[i*4 +: 4]);
         bi  = int'(b[i*4 +: 4]);
         raw = ai + bi + carry;
         if (raw > 9) begin d = (raw + 6) % 16; carry = 1; end
         else begin d = raw; carry = 0; end
         s[i*4 +: 4] = 4'(d);
         if (ai > 9 || bi > 9) e = 1'b1;
      end
      co = (carry != 0);
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit glitch);
      logic [W-1:0] es;
      logic         ec, ee;
      logic [W-1:0] prev_sum;
      logic         prev_cout, prev_err;
      model(a, b, c, es, ec, ee);
      prev_sum = Sum; prev_cout = Cout; prev_err = err;
      A = a; B = b; Cin = c; start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < D; k++) begin
         check("busy_run", 32'(busy), 32'd1);
         check("done_run", 32'(done), 32'd0);
         check("sum_hold", 32'(Sum), 32'(prev_sum));
         check("flags_hold", {30'd0, Cout, err}, {30'd0, prev_cout, prev_err});
         A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
         if (glitch && k == 1) begin A = 16'h1111; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
      end
      check("done", 32'(done), 32'd1);
      check("busy_done", 32'(busy), 32'd0);
      check("sum", 32'(Sum), 32'(es));
      check("cout", 32'(Cout), 32'(ec));
      check("err", 32'(err), 32'(ee));
   endtask

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] v;
      for (int i = 0; i < D; i++)
         v[i*4 +: 4] = (allow_bad && $urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                                 : 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(Sum), 32'd0);
      check("rst_cout_err", {30'd0, Cout, err}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
      run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
      run_op(16'h1234, 16'h5678, 1'b0, 1'b1);
      start = 1'b0;
      @(negedge clk);
      check("single_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Reset during the third RUN cycle aborts the operation.
      A = 16'h9999; B = 16'h0001; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_sum", 32'(Sum), 32'd0);
      check("abort_flags", {29'd0, done, Cout, err}, 32'd0);
      for (int k = 0; k < D + 2; k++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end

      // Reset and start together: reset wins.
      reset = 1'b1; start = 1'b1; A = 16'h1111; B = 16'h1111;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rst_start_idle", 32'(busy), 32'd0);

      run_op(16'h0005, 16'h0005, 1'b0, 1'b0);
      run_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++)
         run_op(rand_bcd(n % 4 == 3), rand_bcd(n % 4 == 3), 1'($urandom), 1'b0);

      start = 1'b0;
      @(negedge clk);
      check("final_idle", 32'(busy), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Multi-digit BCD addition controller that time-shares one single-digit BCD add/correct stage across all digits of two packed BCD operands, least-significant digit first, one digit per clock. It holds the operands, sequences the digit index, carries the decimal carry between digits and publishes the packed result with a start/done handshake. It sits between operand-entry logic and the seven-segment display path, so a multi-digit sum can be shown without replicating the digit adder.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 2..8.
- clk  input  1: single clock; all state updates on the rising edge.
- reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1: request a new addition; acted on only in IDLE.
- A  input  4*DIGITS: operand A, packed BCD, digit i = A[4i+3:4i]; sampled only on the accepting edge.
- B  input  4*DIGITS: operand B, same packing as A.
- Cin  input  1: decimal carry-in to digit 0, sampled with A and B.
- busy  output  1: high while a digit sequence is in progress.
- done  output  1: one-cycle pulse, result valid.
- Sum  output  4*DIGITS: packed BCD result, held until the next completion.
- Cout  output  1: decimal carry out of the top digit.
- err  output  1: at least one input digit of the last operation was greater than 9.

## Operation
- States: IDLE, RUN. Reset → IDLE; busy=0, done=0, Sum=0, Cout=0, err=0, digit index=0, carry register=0, internal operand/partial registers=0.
- IDLE with start=1: latch A, B and Cin into the carry register, clear the partial-sum and error accumulators, set index=0, go to RUN.
- IDLE with start=0: hold all outputs. done returns to 0 after its single cycle.
- RUN, each cycle, on digit i = index:
  - raw = a_i + b_i + carry, 5 bits.
  - If raw > 9: digit = (raw + 6) mod 16, carry_next = 1. Otherwise digit = raw, carry_next = 0.
  - Write digit into partial-sum slot i.
  - err accumulator |= (a_i > 9) | (b_i > 9).
  - index increments.
- On the RUN cycle with index = DIGITS-1, at the following edge:
  - Sum ← full partial sum, including the digit written that cycle.
  - Cout ← carry_next.
  - err ← accumulator.
  - done ← 1, busy ← 0, state ← IDLE.
- Invalid digits (> 9) do not abort the operation. The same correction rule is applied and err is flagged.
- start while busy=1 is ignored and not queued. A, B and Cin changes during RUN have no effect.
- Sum, Cout and err keep their previous values throughout RUN. They change only on the completion edge, or on reset.

## Timing
- Let start be sampled high at edge E0. Then:
  - busy=1 from E0 for exactly DIGITS cycles.
  - done=1 for the cycle after edge E0+DIGITS.
  - busy=0 in that same cycle.
- Latency from start to done is DIGITS+1 cycles: 5 for the default.
- Back-to-back operation: start high in the done cycle is accepted, giving one result every DIGITS+1 cycles.
- Reset mid-RUN: the next edge forces IDLE and all outputs to their reset values. No done is produced for the aborted operation.
- Reset and start in the same cycle: reset wins, and start is ignored.
- Index width is ceil(log2(DIGITS)). It never exceeds DIGITS-1; the index is cleared on completion.

## Test plan
- A=16'h1234, B=16'h5678, Cin=0, start pulse → busy high 4 cycles, then done pulse with Sum=16'h6912, Cout=0, err=0, 5 cycles after start.
- A=16'h9999, B=16'h0001, Cin=0 → Sum=16'h0000, Cout=1, which checks carry ripple through every digit. Then A=16'h0000, B=16'h0000, Cin=1 → Sum=16'h0001, Cout=0.
- A=16'h9999, B=16'h9999, Cin=1 → Sum=16'h9999, Cout=1 (maximum case, raw=19 per digit).
- Start a 1234+5678 operation; pulse start with A=16'h1111 at cycle 2 of RUN → that start is ignored, and the result is 16'h6912 with exactly one done pulse.
- Start 9999+0001; assert reset during RUN cycle 3 → next cycle busy=0, Sum=0, Cout=0, err=0, and no done. Then start 0005+0005 → Sum=16'h0010.
- A=16'h00A0, B=16'h0000 → err=1 with done. A following valid operation 0001+0001 → err=0, Sum=16'h0002.
